// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Integer register file for the pipelined core with a per-register busy
// scoreboard. x0 always reads as zero and is never written or marked.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (clears data, busy bits, count)
//   regWrite     writeback write enable
//   writeReg     writeback address
//   dataWrite    writeback data
//   markValid    issue strobe: markReg becomes pending
//   markReg      destination register being issued
//   readRegs     NRD flattened read addresses, port k at [k*DEPTH_LOG2 +: DEPTH_LOG2]
//   readData     NRD flattened read data, port k at [k*WIDTH +: WIDTH] (combinational)
//   readBusy     per-port pending flag for the addressed register (combinational)
//   pendingCount number of registers currently busy (registered)
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 5,
  parameter int NRD        = 2,
  parameter int BYPASS     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      regWrite,
  input  logic [DEPTH_LOG2-1:0]     writeReg,
  input  logic [WIDTH-1:0]          dataWrite,
  input  logic                      markValid,
  input  logic [DEPTH_LOG2-1:0]     markReg,
  input  logic [NRD*DEPTH_LOG2-1:0] readRegs,
  output logic [NRD*WIDTH-1:0]      readData,
  output logic [NRD-1:0]            readBusy,
  output logic [DEPTH_LOG2:0]       pendingCount
);

  localparam int NENT = 2 ** DEPTH_LOG2;
  localparam int CW   = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem_q [NENT];
  logic [NENT-1:0]       busy_q;
  logic [NENT-1:0]       busy_d;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  wr_en_s;
  logic                  mark_en_s;
  logic                  inc_s;
  logic                  dec_s;
  logic [DEPTH_LOG2-1:0] rd_addr_s [NRD];

  // Qualified write/mark strobes: anything aimed at x0 is dropped.
  always_comb begin
    wr_en_s   = regWrite && (writeReg != {DEPTH_LOG2{1'b0}});
    mark_en_s = markValid && (markReg != {DEPTH_LOG2{1'b0}});
  end

  // Next busy vector and count delta. The set is applied after the clear so a
  // same-register mark/write leaves the register pending (new producer wins).
  always_comb begin
    busy_d = busy_q;
    if (wr_en_s) begin
      busy_d[writeReg] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (mark_en_s) begin
      busy_d[markReg] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    // Count only real 0->1 and 1->0 transitions.
    inc_s   = mark_en_s && !busy_q[markReg];
    dec_s   = wr_en_s && busy_q[writeReg] && !(mark_en_s && (markReg == writeReg));
    count_d = count_q + CW'(inc_s) - CW'(dec_s);
  end

  // Register storage: cleared on reset, written from the writeback port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_q[writeReg] <= dataWrite;
    end
  end

  // Scoreboard state: busy bits and the pending counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= {NENT{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign pendingCount = count_q;

  // Unpack the flattened read addresses.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_addr_s[k] = readRegs[k*DEPTH_LOG2 +: DEPTH_LOG2];
    end
  end

  // Read ports. A forwarded write also hides the stale busy bit, unless the
  // same register is being re-issued this cycle.
  always_comb begin
    readData = {(NRD*WIDTH){1'b0}};
    readBusy = {NRD{1'b0}};
    for (int k = 0; k < NRD; k++) begin
      if (rd_addr_s[k] == {DEPTH_LOG2{1'b0}}) begin
        readData[k*WIDTH +: WIDTH] = {WIDTH{1'b0}};
        readBusy[k]                = 1'b0;
      end else if ((BYPASS != 0) && regWrite && (writeReg == rd_addr_s[k])) begin
        readData[k*WIDTH +: WIDTH] = dataWrite;
        if (mark_en_s && (markReg == rd_addr_s[k])) begin
          readBusy[k] = busy_q[rd_addr_s[k]];
        end else begin
          readBusy[k] = 1'b0;
        end
      end else begin
        readData[k*WIDTH +: WIDTH] = mem_q[rd_addr_s[k]];
        readBusy[k]                = busy_q[rd_addr_s[k]];
      end
    end
  end

endmodule
